// File: rtl/priority_arbiter.sv
// N-input arbiter with a registered one-hot grant that is held until release or hold timeout.
// Arbitration is either fixed priority (highest index wins) or round-robin from a rotating pointer.
module priority_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 0,
    parameter int unsigned IDXW     = $clog2(N)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [N-1:0]    req_i,
    input  logic            rr_en_i,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] gnt_idx_o,
    output logic            gnt_valid_o,
    output logic            any_req_o
);

    localparam int unsigned HoldW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0]  hold_q, hold_d;

    logic              owner_req;
    logic              timeout;
    logic [N-1:0]      arb_req;
    logic [IDXW-1:0]   win_idx;
    logic              win_found;
    logic              take;
    logic              go_idle;

    assign owner_req = |(req_i & gnt_q);
    assign timeout   = (MAX_HOLD != 0) && (hold_q == HoldMax);
    // On timeout the owner is masked out so another requester can win.
    assign arb_req   = ((state_q == StOwned) && owner_req && timeout) ? (req_i & ~gnt_q) : req_i;

    always_comb begin
        logic [N-1:0]   sh;
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [IDXW:0]  sum;
        logic [IDXW-1:0] off;
        win_found = 1'b0;
        win_idx   = '0;
        sh        = '0;
        dbl       = '0;
        rot       = '0;
        sum       = '0;
        off       = '0;
        if (!rr_en_i) begin
            for (int i = 0; i < int'(N); i++) begin
                sh = arb_req >> i;
                if (sh[0]) begin
                    win_idx   = IDXW'(i);
                    win_found = 1'b1;
                end
            end
        end else begin
            // Rotate so bit k of rot is requester (ptr + k) mod N; smallest k wins.
            dbl = {arb_req, arb_req} >> ptr_q;
            rot = dbl[N-1:0];
            for (int k = int'(N) - 1; k >= 0; k--) begin
                sh = rot >> k;
                if (sh[0]) begin
                    off       = IDXW'(k);
                    win_found = 1'b1;
                end
            end
            sum = {1'b0, ptr_q} + {1'b0, off};
            if (sum >= (IDXW + 1)'(N)) begin
                sum = sum - (IDXW + 1)'(N);
            end
            win_idx = sum[IDXW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        take    = 1'b0;
        go_idle = 1'b0;

        unique case (state_q)
            StIdle: begin
                take = win_found;
            end
            StOwned: begin
                if (!owner_req) begin
                    take    = win_found;
                    go_idle = !win_found;
                end else if (timeout) begin
                    take = win_found;
                    if (!win_found) begin
                        hold_d = HoldW'(1);
                    end
                end else if (MAX_HOLD != 0) begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (take) begin
            state_d = StOwned;
            gnt_d   = N'(1) << win_idx;
            idx_d   = win_idx;
            ptr_d   = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);
            hold_d  = HoldW'(1);
        end
        if (go_idle) begin
            state_d = StIdle;
            gnt_d   = '0;
            idx_d   = '0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = (state_q == StOwned);
    assign any_req_o   = |req_i;

endmodule
